// File: rtl/inst_fetch_resp_if.sv
// Handshake and memory bus bundle for the instruction fetch responder.
// slave is the responder view; master is the requester/decode/memory side.
interface inst_fetch_resp_if #(
    parameter int AW = 10
);
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_pc;
    logic          flush;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst;
    logic [31:0]   inst_pc;
    logic          inst_err;

    modport slave (
        input  req_valid, req_pc, flush, imem_rdata, inst_ready,
        output req_ready, imem_en, imem_addr, inst_valid, inst, inst_pc, inst_err
    );

    modport master (
        output req_valid, req_pc, flush, imem_rdata, inst_ready,
        input  req_ready, imem_en, imem_addr, inst_valid, inst, inst_pc, inst_err
    );
endinterface

// File: rtl/inst_fetch_resp.sv
// Fetch responder: PC request -> 1-cycle BRAM read -> output FIFO of {inst, pc, err}.
// Optional fetch/stall counters are enabled by defining FETCH_STATS_EN.
module inst_fetch_resp #(
    parameter int AW    = 10,
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    inst_fetch_resp_if.slave bus
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_stall
`endif
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_U = (CW+1)'(DEPTH);

    typedef enum logic {IDLE, RD} state_t;

    state_t        state;
    logic [31:0]   pend_pc_p1;
    logic          pend_err_p1;

    logic [31:0]   fifo_inst [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];
    logic          fifo_err  [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          aligned;
    logic          accept;
    logic          push;
    logic          pop;
    logic [CW:0]   used;

    // Slots already committed (queued + in flight), less the entry leaving this cycle.
    // Admitting only while this is below DEPTH keeps a free slot for every returning read.
    assign pop     = bus.inst_valid & bus.inst_ready;
    assign used    = {1'b0, count} + (CW+1)'(state == RD) - (CW+1)'(pop);
    assign aligned = (bus.req_pc[1:0] == 2'b00);

    assign bus.req_ready = rst & ~bus.flush & (used < DEPTH_U);
    assign accept        = bus.req_valid & bus.req_ready;
    assign bus.imem_en   = accept & aligned;
    assign bus.imem_addr = rst ? bus.req_pc[AW+1:2] : '0;

    assign push = (state == RD) & ~bus.flush;

    assign bus.inst_valid = (count != '0);
    assign bus.inst       = bus.inst_valid ? fifo_inst[rd_ptr] : 32'h0;
    assign bus.inst_pc    = bus.inst_valid ? fifo_pc[rd_ptr]   : 32'h0;
    assign bus.inst_err   = bus.inst_valid ? fifo_err[rd_ptr]  : 1'b0;

    // p0 -> p1: request accepted, read issued; p1: data returns and is queued
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            pend_pc_p1  <= 32'h0;
            pend_err_p1 <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else if (bus.flush) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= accept ? RD : IDLE;
            if (accept) begin
                pend_pc_p1  <= bus.req_pc;
                pend_err_p1 <= ~aligned;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: entries are only visible while count says so.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr] <= pend_err_p1 ? 32'h0 : bus.imem_rdata;
            fifo_pc[wr_ptr]   <= pend_pc_p1;
            fifo_err[wr_ptr]  <= pend_err_p1;
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_fetched <= 32'h0;
            stat_stall   <= 32'h0;
        end else begin
            if (pop) stat_fetched <= stat_fetched + 32'h1;
            if (bus.req_valid & ~bus.req_ready) stat_stall <= stat_stall + 32'h1;
        end
    end
`endif

endmodule
